// File: rtl/switch_capture_frontend.sv
// -----------------------------------------------------------------------------
// switch_capture_frontend
//
// Input-side companion to the LED jackpot game. The four raw slide switches
// are synchronised, debounced and turned into clean levels and single-cycle
// rising-edge events. A small three-state capture FSM records the first
// switch flip after an arm request, so the game logic can compare it against
// the lit LED.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable cycles before a new level is accepted
//                     (1 .. 2^24-1; 1250000 = 10 ms at 125 MHz)
//   CNT_W           : width of each per-channel counter, must hold
//                     DEBOUNCE_CYCLES-1
//
// Ports
//   CLOCK      in   system clock, 125 MHz
//   RESET      in   asynchronous, active-high reset
//   SWITCHES   in   [3:0] raw asynchronous switch levels
//   ARM        in   one-cycle request to open a capture window
//   HIT_CLEAR  in   one-cycle request to drop a capture and disarm
//   SW_CLEAN   out  [3:0] debounced switch levels
//   SW_RISE    out  [3:0] one-cycle pulse per channel on a clean 0->1
//   ARMED      out  high while the capture window is open
//   HIT_VALID  out  high while a capture is held
//   HIT_ONEHOT out  [3:0] captured channel, one-hot; 0 when HIT_VALID=0
//   HIT_MULTI  out  more than one rise was present in the capture cycle
// -----------------------------------------------------------------------------
module switch_capture_frontend #(
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int CNT_W           = 24
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [3:0] SWITCHES,
  input  logic       ARM,
  input  logic       HIT_CLEAR,
  output logic [3:0] SW_CLEAN,
  output logic [3:0] SW_RISE,
  output logic       ARMED,
  output logic       HIT_VALID,
  output logic [3:0] HIT_ONEHOT,
  output logic       HIT_MULTI
);

  // Terminal count: the level is accepted on the edge where the counter
  // already holds DEBOUNCE_CYCLES-1, so the counter itself never reaches
  // DEBOUNCE_CYCLES and can never wrap.
  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] S_DISARMED = 2'd0;
  localparam logic [1:0] S_ARMED    = 2'd1;
  localparam logic [1:0] S_CAPTURED = 2'd2;

  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] r_clean;
  logic [3:0] r_rise;
  logic [3:0] w_clean_nxt;

  logic [1:0] r_state;
  logic       r_hit_valid;
  logic [3:0] r_hit_onehot;
  logic       r_hit_multi;

  logic [3:0] w_rise_lowest;
  logic       w_rise_multi;
  logic       w_rise_any;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser for all four asynchronous switch inputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_sync1 <= 4'b0000;
      r_sync2 <= 4'b0000;
    end else begin
      r_sync1 <= SWITCHES;
      r_sync2 <= r_sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel debounce counters. Each channel is fully independent: the
  // counter runs only while the synchronised level differs from the accepted
  // clean level, and any return to the clean level restarts it from zero.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < 4; g++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic             w_differs;
    logic             w_expire;

    assign w_differs = r_sync2[g] ^ r_clean[g];
    assign w_expire  = w_differs && (r_cnt == LP_CNT_MAX);

    always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
        r_cnt <= '0;
      end else if (!w_differs || w_expire) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end

    assign w_clean_nxt[g] = w_expire ? r_sync2[g] : r_clean[g];
  end

  // ---------------------------------------------------------------------------
  // Clean level and rise event. The rise pulse is registered on the same edge
  // that updates the clean level, so it is visible for exactly the cycle that
  // follows the 0->1 change; falling transitions never produce a pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_clean <= 4'b0000;
      r_rise  <= 4'b0000;
    end else begin
      r_clean <= w_clean_nxt;
      r_rise  <= w_clean_nxt & ~r_clean;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture decode. Two's-complement trick isolates the lowest set bit, which
  // gives channel 0 the highest priority. Clearing the lowest set bit and
  // testing for anything left tells whether more than one rise coincided.
  // ---------------------------------------------------------------------------
  assign w_rise_lowest = r_rise & (~r_rise + 4'd1);
  assign w_rise_multi  = |(r_rise & (r_rise - 4'd1));
  assign w_rise_any    = |r_rise;

  // ---------------------------------------------------------------------------
  // Capture FSM. HIT_CLEAR has priority over everything, including an ARM in
  // the same cycle. Rises seen outside ARMED are simply dropped, and ARM is
  // only honoured from DISARMED, so a rise coincident with ARM is not taken.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state      <= S_DISARMED;
      r_hit_valid  <= 1'b0;
      r_hit_onehot <= 4'b0000;
      r_hit_multi  <= 1'b0;
    end else if (HIT_CLEAR) begin
      r_state      <= S_DISARMED;
      r_hit_valid  <= 1'b0;
      r_hit_onehot <= 4'b0000;
      r_hit_multi  <= 1'b0;
    end else begin
      case (r_state)
        S_DISARMED: begin
          if (ARM) begin
            r_state <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (w_rise_any) begin
            r_state      <= S_CAPTURED;
            r_hit_valid  <= 1'b1;
            r_hit_onehot <= w_rise_lowest;
            r_hit_multi  <= w_rise_multi;
          end
        end
        S_CAPTURED: begin
          // Hold the capture until HIT_CLEAR.
        end
        default: begin
          // Unreachable encoding: recover to a clean disarmed state.
          r_state      <= S_DISARMED;
          r_hit_valid  <= 1'b0;
          r_hit_onehot <= 4'b0000;
          r_hit_multi  <= 1'b0;
        end
      endcase
    end
  end

  assign SW_CLEAN   = r_clean;
  assign SW_RISE    = r_rise;
  assign ARMED      = (r_state == S_ARMED);
  assign HIT_VALID  = r_hit_valid;
  assign HIT_ONEHOT = r_hit_onehot;
  assign HIT_MULTI  = r_hit_multi;

endmodule

// File: tb/tb_switch_capture_frontend.sv
// -----------------------------------------------------------------------------
// tb_switch_capture_frontend
//
// Directed bench for switch_capture_frontend with DEBOUNCE_CYCLES=4. Inputs
// change 1 ns after a rising edge; outputs are sampled at the same point.
// Observed outputs are packed as
//   {SW_CLEAN[3:0], SW_RISE[3:0], ARMED, HIT_VALID, HIT_ONEHOT[3:0], HIT_MULTI}
// and compared against hand-computed vectors.
// -----------------------------------------------------------------------------
module tb_switch_capture_frontend;

  logic       CLOCK;
  logic       RESET;
  logic [3:0] SWITCHES;
  logic       ARM;
  logic       HIT_CLEAR;
  logic [3:0] SW_CLEAN;
  logic [3:0] SW_RISE;
  logic       ARMED;
  logic       HIT_VALID;
  logic [3:0] HIT_ONEHOT;
  logic       HIT_MULTI;

  int n_vec = 0;
  int n_err = 0;

  logic [14:0] obs;
  assign obs = {SW_CLEAN, SW_RISE, ARMED, HIT_VALID, HIT_ONEHOT, HIT_MULTI};

  switch_capture_frontend #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(24)
  ) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .SWITCHES(SWITCHES),
    .ARM(ARM),
    .HIT_CLEAR(HIT_CLEAR),
    .SW_CLEAN(SW_CLEAN),
    .SW_RISE(SW_RISE),
    .ARMED(ARMED),
    .HIT_VALID(HIT_VALID),
    .HIT_ONEHOT(HIT_ONEHOT),
    .HIT_MULTI(HIT_MULTI)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic test_reset();
    logic [14:0] exp;
    RESET = 1'b1; SWITCHES = 4'b0000; ARM = 1'b0; HIT_CLEAR = 1'b0;
    tick(); tick();
    exp = 15'd0;
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL reset_hold: got %b want %b", obs, exp); end
    RESET = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_vec++;
      if (obs !== exp) begin n_err++; $display("FAIL reset_idle[%0d]: got %b want %b", k, obs, exp); end
    end
    // Reset asserted while channel 0 is mid-count.
    SWITCHES = 4'b0001;
    repeat (4) tick();
    RESET = 1'b1;
    #1;
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL reset_async: got %b want %b", obs, exp); end
    repeat (3) tick();
    SWITCHES = 4'b0000;
    RESET = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_vec++;
      if (obs !== exp) begin n_err++; $display("FAIL reset_midcount[%0d]: got %b want %b", k, obs, exp); end
    end
  endtask

  task automatic test_rise();
    logic [14:0] exp;
    SWITCHES = 4'b0100;
    exp = 15'd0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      n_vec++;
      if (obs !== exp) begin n_err++; $display("FAIL rise_wait E%0d: got %b want %b", e, obs, exp); end
    end
    tick();  // E6
    exp = {4'b0100, 4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0};
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL rise_E6: got %b want %b", obs, exp); end
    tick();  // E7
    exp = {4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0};
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL rise_E7: got %b want %b", obs, exp); end
    // Falling edge: clean drops at E6, no pulse anywhere.
    SWITCHES = 4'b0000;
    for (int e = 1; e <= 5; e++) begin
      tick();
      n_vec++;
      if (obs !== exp) begin n_err++; $display("FAIL fall_wait E%0d: got %b want %b", e, obs, exp); end
    end
    exp = 15'd0;
    for (int e = 6; e <= 7; e++) begin
      tick();
      n_vec++;
      if (obs !== exp) begin n_err++; $display("FAIL fall_E%0d: got %b want %b", e, obs, exp); end
    end
  endtask

  task automatic test_bounce();
    logic [14:0] exp;
    exp = 15'd0;
    for (int b = 0; b < 4; b++) begin
      SWITCHES = (b % 2 == 0) ? 4'b0010 : 4'b0000;
      repeat (2) begin
        tick();
        n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL bounce_phase%0d: got %b want %b", b, obs, exp); end
      end
    end
    SWITCHES = 4'b0010;
    for (int e = 1; e <= 5; e++) begin
      tick();
      n_vec++;
      if (obs !== exp) begin n_err++; $display("FAIL bounce_settle E%0d: got %b want %b", e, obs, exp); end
    end
    tick();  // E6
    exp = {4'b0010, 4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0};
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL bounce_E6: got %b want %b", obs, exp); end
    SWITCHES = 4'b0000;
    repeat (8) tick();
    exp = 15'd0;
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL bounce_release: got %b want %b", obs, exp); end
  endtask

  task automatic test_capture();
    logic [14:0] exp;
    ARM = 1'b1;
    tick();
    ARM = 1'b0;
    SWITCHES = 4'b1000;
    exp = {4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0};
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL cap_armed: got %b want %b", obs, exp); end
    for (int e = 1; e <= 5; e++) begin
      tick();
      n_vec++;
      if (obs !== exp) begin n_err++; $display("FAIL cap_wait E%0d: got %b want %b", e, obs, exp); end
    end
    tick();  // E6: rise visible, not yet captured
    exp = {4'b1000, 4'b1000, 1'b1, 1'b0, 4'b0000, 1'b0};
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL cap_rise: got %b want %b", obs, exp); end
    tick();  // E7: captured
    exp = {4'b1000, 4'b0000, 1'b0, 1'b1, 4'b1000, 1'b0};
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL cap_hit: got %b want %b", obs, exp); end
    // Later rise on channel 0 must not disturb the held capture.
    SWITCHES = 4'b1001;
    repeat (6) tick();
    exp = {4'b1001, 4'b0001, 1'b0, 1'b1, 4'b1000, 1'b0};
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL cap_late_rise: got %b want %b", obs, exp); end
    tick();
    exp = {4'b1001, 4'b0000, 1'b0, 1'b1, 4'b1000, 1'b0};
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL cap_hold: got %b want %b", obs, exp); end
    HIT_CLEAR = 1'b1;
    tick();
    HIT_CLEAR = 1'b0;
    exp = {4'b1001, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0};
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL cap_clear: got %b want %b", obs, exp); end
    SWITCHES = 4'b0000;
    repeat (8) tick();
  endtask

  task automatic test_multi();
    logic [14:0] exp;
    ARM = 1'b1;
    tick();
    ARM = 1'b0;
    SWITCHES = 4'b0110;
    repeat (6) tick();
    exp = {4'b0110, 4'b0110, 1'b1, 1'b0, 4'b0000, 1'b0};
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL multi_rise: got %b want %b", obs, exp); end
    tick();
    exp = {4'b0110, 4'b0000, 1'b0, 1'b1, 4'b0010, 1'b1};
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL multi_hit: got %b want %b", obs, exp); end
    HIT_CLEAR = 1'b1;
    tick();
    HIT_CLEAR = 1'b0;
    exp = {4'b0110, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0};
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL multi_clear: got %b want %b", obs, exp); end
    SWITCHES = 4'b0000;
    repeat (8) tick();
  endtask

  task automatic test_corners();
    logic [14:0] exp;
    // ARM and HIT_CLEAR together: clear wins.
    ARM = 1'b1; HIT_CLEAR = 1'b1;
    tick();
    ARM = 1'b0; HIT_CLEAR = 1'b0;
    exp = 15'd0;
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL arm_and_clear: got %b want %b", obs, exp); end
    // ARM while CAPTURED is ignored.
    ARM = 1'b1;
    tick();
    ARM = 1'b0;
    SWITCHES = 4'b0001;
    repeat (7) tick();
    exp = {4'b0001, 4'b0000, 1'b0, 1'b1, 4'b0001, 1'b0};
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL captured_ch0: got %b want %b", obs, exp); end
    ARM = 1'b1;
    tick();
    ARM = 1'b0;
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL arm_in_captured: got %b want %b", obs, exp); end
    HIT_CLEAR = 1'b1;
    tick();
    HIT_CLEAR = 1'b0;
    SWITCHES = 4'b0000;
    repeat (8) tick();
    // Rise pulse in the same cycle ARM is sampled is not captured.
    SWITCHES = 4'b0100;
    repeat (6) tick();
    exp = {4'b0100, 4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0};
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL disarmed_rise: got %b want %b", obs, exp); end
    ARM = 1'b1;
    tick();
    ARM = 1'b0;
    exp = {4'b0100, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0};
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL arm_with_rise: got %b want %b", obs, exp); end
    repeat (5) tick();
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL arm_rise_dropped: got %b want %b", obs, exp); end
    HIT_CLEAR = 1'b1;
    tick();
    HIT_CLEAR = 1'b0;
    SWITCHES = 4'b0000;
    repeat (8) tick();
    // Rise well before ARM is not queued.
    SWITCHES = 4'b0010;
    repeat (8) tick();
    ARM = 1'b1;
    tick();
    ARM = 1'b0;
    repeat (4) tick();
    exp = {4'b0010, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0};
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL rise_not_queued: got %b want %b", obs, exp); end
    HIT_CLEAR = 1'b1;
    tick();
    HIT_CLEAR = 1'b0;
    SWITCHES = 4'b0000;
    repeat (8) tick();
    exp = 15'd0;
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL corners_idle: got %b want %b", obs, exp); end
  endtask

  task automatic test_high_at_reset();
    logic [14:0] exp;
    RESET = 1'b1;
    SWITCHES = 4'b0001;
    tick();
    RESET = 1'b0;
    exp = 15'd0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      n_vec++;
      if (obs !== exp) begin n_err++; $display("FAIL high_rst_wait E%0d: got %b want %b", e, obs, exp); end
    end
    tick();  // E6
    exp = {4'b0001, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0};
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL high_rst_E6: got %b want %b", obs, exp); end
    tick();
    exp = {4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0};
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL high_rst_E7: got %b want %b", obs, exp); end
    SWITCHES = 4'b0000;
    repeat (8) tick();
  endtask

  initial begin
    RESET = 1'b1;
    SWITCHES = 4'b0000;
    ARM = 1'b0;
    HIT_CLEAR = 1'b0;
    test_reset();
    test_rise();
    test_bounce();
    test_capture();
    test_multi();
    test_corners();
    test_high_at_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
